// File: rtl/rs_branch_if.sv
// Shared uop record for the branch reservation station, plus the bundle of
// dispatch, wakeup, issue and flush signals between the RS and its neighbours.
package rs_branch_pkg;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 4;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              ps1_ready;
    logic              ps2_ready;
    logic [ROB_W-1:0]  rob_index;
  } rs_data;
endpackage

interface rs_branch_if #(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 3
);
  import rs_branch_pkg::*;

  logic                                 disp_valid;
  rs_data                               disp_data;
  logic                                 disp_ready;
  logic [NUM_WB-1:0]                    wb_valid;
  logic [NUM_WB*PREG_W-1:0]             wb_tag;
  logic                                 fu_b_ready;
  logic                                 issued;
  rs_data                               data_out;
  logic [ROB_W-1:0]                     rob_head;
  logic                                 mispredict;
  logic [ROB_W-1:0]                     mispredict_tag;
  logic [$clog2(DEPTH):0]               count;

  modport master (
    output disp_valid, disp_data, wb_valid, wb_tag, fu_b_ready,
           rob_head, mispredict, mispredict_tag,
    input  disp_ready, issued, data_out, count
  );

  modport slave (
    input  disp_valid, disp_data, wb_valid, wb_tag, fu_b_ready,
           rob_head, mispredict, mispredict_tag,
    output disp_ready, issued, data_out, count
  );
endinterface

// File: rtl/rs_branch.sv
// Branch-pipe reservation station: holds renamed branch uops, wakes them on
// writeback tags, issues the oldest ready one and squashes wrong-path entries.
module rs_branch
  import rs_branch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 3
) (
  input  logic        clk,
  input  logic        reset,
  rs_branch_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  rs_data           entry_q [DEPTH];
  rs_data           entry_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             issued_q, issued_d;
  rs_data           data_out_q, data_out_d;

  logic [ROB_W-1:0] age [DEPTH];
  logic [ROB_W-1:0] flush_age;
  logic [DEPTH-1:0] cand, squash, wake1, wake2;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [ROB_W-1:0] sel_age;
  logic [IDX_W-1:0] alloc_idx;
  logic             disp_ready;
  logic             disp_fire;
  logic             issue_fire;
  rs_data           disp_entry;
  logic [CNT_W-1:0] squash_cnt;

  function automatic logic tag_hit(
    input logic [PREG_W-1:0]        tag,
    input logic [NUM_WB-1:0]        wv,
    input logic [NUM_WB*PREG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wv[p] && (wt[p*PREG_W +: PREG_W] != '0) && (wt[p*PREG_W +: PREG_W] == tag))
        hit = 1'b1;
    end
    return hit;
  endfunction

  // Age is relative to the ROB head so index wrap-around never matters.
  assign flush_age = bus.mispredict_tag - bus.rob_head;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign age[gi]    = entry_q[gi].rob_index - bus.rob_head;
    assign cand[gi]   = valid_q[gi] & entry_q[gi].ps1_ready & entry_q[gi].ps2_ready;
    assign squash[gi] = valid_q[gi] & bus.mispredict & (age[gi] > flush_age);
    assign wake1[gi]  = tag_hit(entry_q[gi].ps1, bus.wb_valid, bus.wb_tag);
    assign wake2[gi]  = tag_hit(entry_q[gi].ps2, bus.wb_valid, bus.wb_tag);
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && (!sel_found || (age[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i])
        alloc_idx = IDX_W'(i);
    end
  end

  assign disp_ready = (count_q < FULL);
  assign disp_fire  = bus.disp_valid & disp_ready & ~bus.mispredict;
  assign issue_fire = bus.fu_b_ready & sel_found & ~bus.mispredict;

  // An incoming uop sees this cycle's broadcasts so its wakeup is not lost.
  always_comb begin
    disp_entry = bus.disp_data;
    disp_entry.ps1_ready = bus.disp_data.ps1_ready | (bus.disp_data.ps1 == '0) |
                           tag_hit(bus.disp_data.ps1, bus.wb_valid, bus.wb_tag);
    disp_entry.ps2_ready = bus.disp_data.ps2_ready | (bus.disp_data.ps2 == '0) |
                           tag_hit(bus.disp_data.ps2, bus.wb_valid, bus.wb_tag);
  end

  always_comb begin
    valid_d    = valid_q;
    entry_d    = entry_q;
    squash_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wake1[i]) entry_d[i].ps1_ready = 1'b1;
      if (wake2[i]) entry_d[i].ps2_ready = 1'b1;
      if (squash[i]) begin
        valid_d[i] = 1'b0;
        squash_cnt = squash_cnt + CNT_W'(1);
      end
    end
    if (issue_fire)
      valid_d[sel_idx] = 1'b0;
    if (disp_fire) begin
      valid_d[alloc_idx] = 1'b1;
      entry_d[alloc_idx] = disp_entry;
    end
    issued_d   = issue_fire;
    data_out_d = issue_fire ? entry_q[sel_idx] : '0;
    count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire) - squash_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      count_q    <= '0;
      issued_q   <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        entry_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      data_out_q <= data_out_d;
      for (int i = 0; i < DEPTH; i++)
        entry_q[i] <= entry_d[i];
    end
  end

  assign bus.disp_ready = disp_ready;
  assign bus.issued     = issued_q;
  assign bus.data_out   = data_out_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_rs_branch.sv
// Scenario bench for rs_branch: expected issue order is queued at stimulus
// time and compared against the issues captured from the DUT.
module tb_rs_branch;
  import rs_branch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_q[$];
  int   obs_q[$];

  always #5 clk = ~clk;

  rs_branch_if #(.DEPTH(8), .NUM_WB(3)) bus ();

  rs_branch #(.DEPTH(8), .NUM_WB(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.issued === 1'b1) begin
      obs_q.push_back(int'(bus.data_out.rob_index));
      $display("issue rob=%0d pc=%h count=%0d", bus.data_out.rob_index, bus.data_out.pc, bus.count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rs_data mk(input int rob, input int p1, input bit r1, input int p2, input bit r2);
    rs_data d;
    d           = '0;
    d.opcode    = 7'b1100011;
    d.func3     = 3'b001;
    d.pc        = 32'h1000 + 32'(rob * 4);
    d.imm       = 32'h10;
    d.pd        = '0;
    d.ps1       = PREG_W'(p1);
    d.ps2       = PREG_W'(p2);
    d.ps1_ready = r1;
    d.ps2_ready = r2;
    d.rob_index = ROB_W'(rob);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid     = 1'b0;
    bus.disp_data      = '0;
    bus.wb_valid       = '0;
    bus.wb_tag         = '0;
    bus.mispredict     = 1'b0;
    bus.mispredict_tag = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.fu_b_ready = 1'b0;
    bus.rob_head   = '0;
    repeat (2) tick();
    n_checks++; if (bus.disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b expected 1", bus.disp_ready); end
    n_checks++; if (bus.issued !== 1'b0) begin n_fail++; $display("FAIL reset_issued: got %b expected 0", bus.issued); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    obs_q.delete(); exp_q.delete();
    bus.fu_b_ready = 1'b1;
    bus.rob_head   = 4'd0;
    bus.disp_data  = mk(2, 0, 1, 0, 1);
    bus.disp_valid = 1'b1;
    exp_q.push_back(2);
    tick();
    idle();
    n_checks++; if (bus.issued !== 1'b0) begin n_fail++; $display("FAIL single_early_issue: got %b expected 0", bus.issued); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", bus.count); end
    tick();
    n_checks++; if (bus.issued !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b expected 1", bus.issued); end
    n_checks++; if (bus.data_out.rob_index !== 4'd2) begin n_fail++; $display("FAIL single_rob: got %0d expected 2", bus.data_out.rob_index); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", bus.count); end
    tick();
    n_checks++; if (bus.issued !== 1'b0 || bus.data_out !== '0) begin n_fail++; $display("FAIL single_pulse: got issued=%b data=%h expected 0/0", bus.issued, bus.data_out); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else if (obs_q[0] != exp_q[0]) begin n_fail++; $display("FAIL single_sb: got %0d expected %0d", obs_q[0], exp_q[0]); end
  endtask

  task automatic test_fill();
    int order[8] = '{5, 2, 7, 0, 3, 6, 1, 4};
    int e, o;
    obs_q.delete(); exp_q.delete();
    bus.fu_b_ready = 1'b1;
    bus.rob_head   = 4'd0;
    for (int k = 0; k < 8; k++) begin
      bus.disp_data  = mk(order[k], 10, 0, 0, 1);
      bus.disp_valid = 1'b1;
      tick();
    end
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_count8: got %0d expected 8", bus.count); end
    n_checks++; if (bus.disp_ready !== 1'b0) begin n_fail++; $display("FAIL fill_not_ready: got %b expected 0", bus.disp_ready); end
    bus.disp_data = mk(9, 0, 1, 0, 1);
    tick();
    idle();
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_overflow_count: got %0d expected 8", bus.count); end
    n_checks++; if (bus.issued !== 1'b0) begin n_fail++; $display("FAIL fill_no_issue: got %b expected 0", bus.issued); end
    bus.wb_valid = 3'b001;
    bus.wb_tag[6:0] = 7'd10;
    tick();
    idle();
    n_checks++; if (bus.issued !== 1'b0) begin n_fail++; $display("FAIL fill_wake_same_cycle: got %b expected 0", bus.issued); end
    for (int k = 0; k < 8; k++) exp_q.push_back(k);
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (bus.issued !== 1'b1) begin n_fail++; $display("FAIL fill_b2b_issue%0d: got %b expected 1", k, bus.issued); end
    end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL fill_drained: got %0d expected 0", bus.count); end
    repeat (3) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fill_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++; if (o != e) begin n_fail++; $display("FAIL fill_order: got rob %0d expected rob %0d", o, e); end
      end
    end
  endtask

  task automatic test_wrap();
    int e, o;
    obs_q.delete(); exp_q.delete();
    bus.fu_b_ready = 1'b0;
    bus.rob_head   = 4'd14;
    bus.disp_data  = mk(1, 0, 1, 0, 1);
    bus.disp_valid = 1'b1;
    tick();
    bus.disp_data  = mk(15, 0, 1, 0, 1);
    tick();
    idle();
    n_checks++; if (bus.count !== 4'd2 || bus.issued !== 1'b0) begin n_fail++; $display("FAIL wrap_hold: got count=%0d issued=%b expected 2/0", bus.count, bus.issued); end
    exp_q.push_back(15); exp_q.push_back(1);
    bus.fu_b_ready = 1'b1;
    repeat (4) tick();
    bus.rob_head = 4'd0;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++; if (o != e) begin n_fail++; $display("FAIL wrap_order: got rob %0d expected rob %0d", o, e); end
      end
    end
  endtask

  task automatic test_same_cycle_wakeup();
    obs_q.delete(); exp_q.delete();
    bus.fu_b_ready = 1'b1;
    bus.rob_head   = 4'd0;
    bus.disp_data  = mk(3, 0, 1, 5, 0);
    bus.disp_valid = 1'b1;
    bus.wb_valid   = 3'b010;
    bus.wb_tag[13:7] = 7'd5;
    exp_q.push_back(3);
    tick();
    idle();
    n_checks++; if (bus.issued !== 1'b0 || bus.count !== 4'd1) begin n_fail++; $display("FAIL scw_stored: got issued=%b count=%0d expected 0/1", bus.issued, bus.count); end
    tick();
    n_checks++; if (bus.issued !== 1'b1) begin n_fail++; $display("FAIL scw_issue: got %b expected 1", bus.issued); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL scw_count: got %0d expected 0", bus.count); end
    tick();
    n_checks++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL scw_sb_size: got %0d expected 1", obs_q.size()); end
    else if (obs_q[0] != exp_q[0]) begin n_fail++; $display("FAIL scw_sb: got rob %0d expected rob %0d", obs_q[0], exp_q[0]); end
  endtask

  task automatic test_flush();
    int e, o;
    rs_data seq[4];
    obs_q.delete(); exp_q.delete();
    seq[0] = mk(0, 0, 1, 0, 1);
    seq[1] = mk(1, 20, 0, 0, 1);
    seq[2] = mk(3, 20, 0, 0, 1);
    seq[3] = mk(5, 20, 0, 0, 1);
    bus.fu_b_ready = 1'b0;
    bus.rob_head   = 4'd0;
    for (int k = 0; k < 4; k++) begin
      bus.disp_data  = seq[k];
      bus.disp_valid = 1'b1;
      tick();
    end
    n_checks++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 4", bus.count); end
    bus.fu_b_ready     = 1'b1;
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 4'd2;
    bus.disp_data      = mk(6, 0, 1, 0, 1);
    bus.disp_valid     = 1'b1;
    tick();
    idle();
    n_checks++; if (bus.issued !== 1'b0) begin n_fail++; $display("FAIL flush_issue_suppressed: got %b expected 0", bus.issued); end
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL flush_count: got %0d expected 2", bus.count); end
    exp_q.push_back(0); exp_q.push_back(1);
    tick();
    n_checks++; if (bus.issued !== 1'b1 || bus.data_out.rob_index !== 4'd0) begin n_fail++; $display("FAIL flush_survivor0: got issued=%b rob=%0d expected 1/0", bus.issued, bus.data_out.rob_index); end
    bus.wb_valid = 3'b100;
    bus.wb_tag[20:14] = 7'd20;
    tick();
    idle();
    tick();
    n_checks++; if (bus.issued !== 1'b1 || bus.data_out.rob_index !== 4'd1) begin n_fail++; $display("FAIL flush_survivor1: got issued=%b rob=%0d expected 1/1", bus.issued, bus.data_out.rob_index); end
    repeat (4) tick();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_final_count: got %0d expected 0", bus.count); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL flush_sb_size: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++; if (o != e) begin n_fail++; $display("FAIL flush_order: got rob %0d expected rob %0d", o, e); end
      end
    end
  endtask

  task automatic test_stall_and_reset();
    obs_q.delete(); exp_q.delete();
    bus.fu_b_ready = 1'b0;
    bus.rob_head   = 4'd0;
    bus.disp_data  = mk(4, 0, 1, 0, 1);
    bus.disp_valid = 1'b1;
    tick();
    bus.disp_data  = mk(5, 0, 1, 0, 1);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus.issued !== 1'b0) begin n_fail++; $display("FAIL stall_issued%0d: got %b expected 0", k, bus.issued); end
    end
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL stall_count: got %0d expected 2", bus.count); end
    bus.fu_b_ready = 1'b1;
    tick();
    n_checks++; if (bus.issued !== 1'b1 || bus.data_out.rob_index !== 4'd4) begin n_fail++; $display("FAIL stall_release: got issued=%b rob=%0d expected 1/4", bus.issued, bus.data_out.rob_index); end
    bus.fu_b_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.disp_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_disp_ready: got %b expected 1", bus.disp_ready); end
    n_checks++; if (bus.data_out !== '0 || bus.issued !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got issued=%b data=%h expected 0/0", bus.issued, bus.data_out); end
    tick();
    reset = 1'b0;
    bus.fu_b_ready = 1'b1;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_retained: got %0d issues expected 0", obs_q.size()); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL midreset_after_count: got %0d expected 0", bus.count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_same_cycle_wakeup();
    test_flush();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
